// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modular up/down counter: direction encoding and
// the terminal (wrap-around) value helper.
package mod_counter_pkg;

    localparam logic CNT_DOWN = 1'b0;
    localparam logic CNT_UP   = 1'b1;

    // Value at which the counter wraps when moving in direction dir.
    function automatic int unsigned terminal_value(input logic dir, input int unsigned modulus);
        return (dir == CNT_UP) ? (modulus - 1) : 0;
    endfunction

endpackage

// File: rtl/count_prescaler.sv
// Enabled-cycle prescaler: counts enabled cycles 0..PRESCALE-1 and pulses tick
// on the enabled cycle at PRESCALE-1. clr restarts the interval.
module count_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with synchronous load, cascade carry and a
// registered wrap pulse. Define MOD_COUNTER_PRESCALE_EN to insert a prescaler.
module mod_updown_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] R,
    input  logic             l,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             carry_out,
    output logic             wrap
);

    localparam longint MOD_LIMIT = longint'(1) << WIDTH;

    if (MODULUS < 2) begin : g_err_mod_lo
        $error("mod_updown_counter: MODULUS must be at least 2");
    end
    if (longint'(MODULUS) > MOD_LIMIT) begin : g_err_mod_hi
        $error("mod_updown_counter: MODULUS must not exceed 2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_err_pre
        $error("mod_updown_counter: PRESCALE must be at least 1");
    end

    localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(terminal_value(CNT_UP, MODULUS));
    localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(terminal_value(CNT_DOWN, MODULUS));

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             step;
    logic             at_term;
    logic [WIDTH-1:0] load_val;

`ifdef MOD_COUNTER_PRESCALE_EN
    logic tick;

    count_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .resetn(resetn),
        .en    (en),
        .clr   (l),
        .tick  (tick)
    );

    assign step = en & tick;
`else
    assign step = en;
`endif

    assign at_term  = (q_q == ((up == CNT_UP) ? TERM_UP : TERM_DN));
    // Out-of-range load values saturate to the top of the count range.
    assign load_val = (R > TERM_UP) ? TERM_UP : R;

    assign carry_out = step & ~l & at_term;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (l) begin
            q_d = load_val;
        end else if (step) begin
            wrap_d = at_term;
            if (up == CNT_UP) begin
                q_d = at_term ? TERM_DN : q_q + WIDTH'(1);
            end else begin
                q_d = at_term ? TERM_UP : q_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;

endmodule
